// File: rtl/rsa_host_driver.sv
// rsa_host_driver
//   Plays the ARM side of the ARM<->FPGA RSA command/data protocol. One start
//   request runs a full exponentiation against the RSA wrapper:
//     CMD 0 + Cipher, CMD 1 + {p,dp}, CMD 2 + {R2p,Rp}, CMD 3 (compute),
//     CMD 4 + read back. Each command ends with a done / done_read handshake.
//   The operands are latched when start is accepted. The upper 512 bits of the
//   read-back word are kept in result, and done pulses once.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   start                     one-cycle request, taken only in IDLE
//   cipher_in/pdp_in/r2prp_in operands sent with CMD 0/1/2
//   busy, done, error         sequence status (error is sticky until next start)
//   result                    captured fpga_to_arm_data[TX_SIZE-1 -: 512]
//   arm_to_fpga_cmd[_valid]   command word and its one-cycle strobe
//   fpga_to_arm_done          responder command-complete
//   fpga_to_arm_done_read     acknowledge, held until done is seen low
//   arm_to_fpga_data*         outbound valid/ready/data
//   fpga_to_arm_data*         inbound valid/ready/data
module rsa_host_driver #(
  parameter int TX_SIZE        = 1024,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [TX_SIZE-1:0] cipher_in,
  input  logic [TX_SIZE-1:0] pdp_in,
  input  logic [TX_SIZE-1:0] r2prp_in,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [511:0]       result,
  output logic [31:0]        arm_to_fpga_cmd,
  output logic               arm_to_fpga_cmd_valid,
  input  logic               fpga_to_arm_done,
  output logic               fpga_to_arm_done_read,
  output logic               arm_to_fpga_data_valid,
  input  logic               arm_to_fpga_data_ready,
  output logic [TX_SIZE-1:0] arm_to_fpga_data,
  input  logic               fpga_to_arm_data_valid,
  output logic               fpga_to_arm_data_ready,
  input  logic [TX_SIZE-1:0] fpga_to_arm_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_TX_DATA,
    S_RX_DATA,
    S_WAIT_DONE,
    S_ACK,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [2:0]         step, step_nxt;
  logic [31:0]        tmo_cnt, tmo_cnt_nxt;
  logic               busy_nxt, done_nxt, error_nxt;
  logic [511:0]       result_nxt;
  logic [31:0]        cmd_nxt;
  logic               cmd_valid_nxt, done_read_nxt;
  logic               tx_valid_nxt, rx_ready_nxt;
  logic [TX_SIZE-1:0] tx_data_nxt;
  logic               load_ops;
  logic [2:0]         step_inc;

  logic [TX_SIZE-1:0] cipher_q, pdp_q, r2prp_q;
  logic [TX_SIZE-1:0] op_sel;
  logic               timeout_hit;

  // Only the top half of the read-back word carries the result.
  logic unused_rx_low;
  assign unused_rx_low = ^fpga_to_arm_data[TX_SIZE-513:0];

  assign timeout_hit = (tmo_cnt == TMO_LAST);
  assign step_inc    = step + 3'd1;

  always_comb begin
    case (step[1:0])
      2'd0:    op_sel = cipher_q;
      2'd1:    op_sel = pdp_q;
      default: op_sel = r2prp_q;
    endcase
  end

  // Operand capture; plain data registers, loaded only on an accepted start.
  always_ff @(posedge clk) begin
    if (load_ops) begin
      cipher_q <= cipher_in;
      pdp_q    <= pdp_in;
      r2prp_q  <= r2prp_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                  <= S_IDLE;
      step                   <= 3'd0;
      tmo_cnt                <= 32'd0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
      result                 <= '0;
      arm_to_fpga_cmd        <= 32'd0;
      arm_to_fpga_cmd_valid  <= 1'b0;
      fpga_to_arm_done_read  <= 1'b0;
      arm_to_fpga_data_valid <= 1'b0;
      arm_to_fpga_data       <= '0;
      fpga_to_arm_data_ready <= 1'b0;
    end else begin
      state                  <= state_nxt;
      step                   <= step_nxt;
      tmo_cnt                <= tmo_cnt_nxt;
      busy                   <= busy_nxt;
      done                   <= done_nxt;
      error                  <= error_nxt;
      result                 <= result_nxt;
      arm_to_fpga_cmd        <= cmd_nxt;
      arm_to_fpga_cmd_valid  <= cmd_valid_nxt;
      fpga_to_arm_done_read  <= done_read_nxt;
      arm_to_fpga_data_valid <= tx_valid_nxt;
      arm_to_fpga_data       <= tx_data_nxt;
      fpga_to_arm_data_ready <= rx_ready_nxt;
    end
  end

  // Next-state logic. Every protocol output is a register, so each value is
  // set on the transition into the state in which it must be visible.
  always_comb begin
    state_nxt     = state;
    step_nxt      = step;
    tmo_cnt_nxt   = 32'd0;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    error_nxt     = error;
    result_nxt    = result;
    cmd_nxt       = arm_to_fpga_cmd;
    cmd_valid_nxt = 1'b0;
    done_read_nxt = fpga_to_arm_done_read;
    tx_valid_nxt  = arm_to_fpga_data_valid;
    tx_data_nxt   = arm_to_fpga_data;
    rx_ready_nxt  = fpga_to_arm_data_ready;
    load_ops      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          load_ops      = 1'b1;
          error_nxt     = 1'b0;
          busy_nxt      = 1'b1;
          step_nxt      = 3'd0;
          cmd_nxt       = 32'd0;
          cmd_valid_nxt = 1'b1;
          state_nxt     = S_CMD;
        end
      end

      S_CMD: begin
        if (step < 3'd3) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = op_sel;
          state_nxt    = S_TX_DATA;
        end else if (step == 3'd3) begin
          state_nxt = S_WAIT_DONE;
        end else begin
          rx_ready_nxt = 1'b1;
          state_nxt    = S_RX_DATA;
        end
      end

      S_TX_DATA: begin
        if (arm_to_fpga_data_ready) begin
          tx_valid_nxt = 1'b0;
          tx_data_nxt  = '0;
          state_nxt    = S_WAIT_DONE;
        end else if (!timeout_hit) begin
          tmo_cnt_nxt = tmo_cnt + 32'd1;
        end
      end

      S_RX_DATA: begin
        if (fpga_to_arm_data_valid && fpga_to_arm_data_ready) begin
          result_nxt   = fpga_to_arm_data[TX_SIZE-1 -: 512];
          rx_ready_nxt = 1'b0;
          state_nxt    = S_WAIT_DONE;
        end else if (!timeout_hit) begin
          tmo_cnt_nxt = tmo_cnt + 32'd1;
        end
      end

      S_WAIT_DONE: begin
        if (fpga_to_arm_done) begin
          done_read_nxt = 1'b1;
          state_nxt     = S_ACK;
        end else if (!timeout_hit) begin
          tmo_cnt_nxt = tmo_cnt + 32'd1;
        end
      end

      // Hold the acknowledge until the responder's (registered) done drops,
      // so a lagging done is never taken as completion of the next command.
      S_ACK: begin
        if (!fpga_to_arm_done) begin
          done_read_nxt = 1'b0;
          step_nxt      = step_inc;
          if (step == 3'd4) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_FINISH;
          end else begin
            cmd_nxt       = {29'd0, step_inc};
            cmd_valid_nxt = 1'b1;
            state_nxt     = S_CMD;
          end
        end else if (!timeout_hit) begin
          tmo_cnt_nxt = tmo_cnt + 32'd1;
        end
      end

      S_FINISH: state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Timeout in any wait state overrides the state's own decision.
    if ((state == S_TX_DATA || state == S_RX_DATA || state == S_WAIT_DONE ||
         state == S_ACK) && timeout_hit &&
        !((state == S_TX_DATA   && arm_to_fpga_data_ready) ||
          (state == S_RX_DATA   && fpga_to_arm_data_valid && fpga_to_arm_data_ready) ||
          (state == S_WAIT_DONE && fpga_to_arm_done) ||
          (state == S_ACK       && !fpga_to_arm_done))) begin
      cmd_nxt       = 32'd0;
      cmd_valid_nxt = 1'b0;
      done_read_nxt = 1'b0;
      tx_valid_nxt  = 1'b0;
      tx_data_nxt   = '0;
      rx_ready_nxt  = 1'b0;
      error_nxt     = 1'b1;
      done_nxt      = 1'b1;
      busy_nxt      = 1'b0;
      tmo_cnt_nxt   = 32'd0;
      state_nxt     = S_ERROR;
    end
  end

endmodule

// File: doc/rsa_host_driver.md
Name: rsa_host_driver

Overview:
- Hardware initiator for the ARM-to-FPGA RSA command/data protocol; it plays the ARM side.
- Sequences one full exponentiation against the RSA wrapper: load Cipher, load p|dp, load R2p|Rp, compute, read back.
- Used as a standalone host in FPGA-only builds and as the stimulus master in system benches.
- Operands are latched at start; the 512-bit result is presented with a done pulse.

Parameters:
TX_SIZE, 1024, width of the data buses in both directions.
TIMEOUT_CYCLES, 2**24, maximum cycles spent in any wait state before error is raised (must be >= 2).

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle request; accepted only when busy=0
cipher_in  input  TX_SIZE  ciphertext, sent with CMD 0
pdp_in  input  TX_SIZE  {p[511:0], dp[511:0]}, sent with CMD 1
r2prp_in  input  TX_SIZE  {R2p[511:0], Rp[511:0]}, sent with CMD 2
busy  output  1  high from the cycle after start is accepted until done/error
done  output  1  one-cycle pulse at end of sequence (success or error)
error  output  1  sticky timeout flag; cleared on the next accepted start
result  output  512  captured fpga_to_arm_data[1023:512]
arm_to_fpga_cmd  output  32  command word
arm_to_fpga_cmd_valid  output  1  command strobe
fpga_to_arm_done  input  1  responder command-complete
fpga_to_arm_done_read  output  1  acknowledge of done
arm_to_fpga_data_valid  output  1  outbound data valid
arm_to_fpga_data_ready  input  1  responder ready for data
arm_to_fpga_data  output  TX_SIZE  outbound data
fpga_to_arm_data_valid  input  1  inbound data valid
fpga_to_arm_data_ready  output  1  accept inbound data
fpga_to_arm_data  input  TX_SIZE  inbound data

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0, including result, error, cmd=0, arm_to_fpga_data=0, step index=0. Reset mid-sequence abandons the transaction with no done pulse.
- Commands: 0=READ_Cipher, 1=READ_pdp, 2=READ_R2pRp, 3=COMPUTE, 4=WRITE. They are issued in this order, step index 0..4.
- All protocol outputs are registered.
- IDLE: start=1 latches the three operand inputs, clears error, sets busy, step=0 -> CMD.
- CMD:
  - cmd_valid=1 for exactly one cycle with arm_to_fpga_cmd=step.
  - Step 0-2 -> TX_DATA; step 3 -> WAIT_DONE; step 4 -> RX_DATA.
- TX_DATA:
  - Drive arm_to_fpga_data with the latched operand for the step, valid=1.
  - Hold both until arm_to_fpga_data_ready=1 is sampled. Responder ready lags its state by one cycle; valid must stay high through that gap.
  - Drop valid the next cycle -> WAIT_DONE.
- RX_DATA:
  - fpga_to_arm_data_ready=1 while waiting.
  - On fpga_to_arm_data_valid=1 && ready=1: result <= fpga_to_arm_data[1023:512]; drop ready next cycle -> WAIT_DONE.
- WAIT_DONE: wait for fpga_to_arm_done=1 -> ACK.
- ACK:
  - fpga_to_arm_done_read=1, held until fpga_to_arm_done is sampled 0. This tolerates the responder's registered done lag and prevents stale-done re-acceptance.
  - Then done_read=0; step+1.
  - If step was 4 -> FINISH, else -> CMD.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Timeout:
  - A 32-bit counter resets on each state entry and counts in TX_DATA, RX_DATA, WAIT_DONE and ACK.
  - At TIMEOUT_CYCLES-1 -> ERROR: all protocol outputs 0, error=1, done pulse, busy=0 -> IDLE.
  - result keeps its last value.
- start while busy=1 is ignored.
- start in the same cycle as the FINISH/ERROR done pulse is ignored; it is accepted in IDLE only.
- Inbound valid outside RX_DATA and unexpected done outside WAIT_DONE/ACK are ignored.

Test Plan:
1. Full sequence against a cycle-accurate responder model: cipher=0x5, pdp={p=0xB,dp=0x3}, responder returns {512'h..0125, 512'h0} -> cmd sequence 0,1,2,3,4, each cmd_valid exactly 1 cycle; result=0x125; done pulses once; busy low after.
2. Responder ready delayed 7 cycles after cmd in step 1 -> arm_to_fpga_data_valid held with pdp stable all 7 cycles; data dropped exactly one cycle after ready sampled.
3. Done held high 3 extra cycles after done_read -> done_read stays high until done=0; no second command issued early; step count correct.
4. Responder never asserts done after CMD 3, TIMEOUT_CYCLES=16 -> error=1 and done pulse 16 cycles after WAIT_DONE entry; next start clears error.
5. Assert resetn=0 mid-compute (step 3, WAIT_DONE) -> all outputs 0 asynchronously, no done pulse; new start runs a clean sequence.
6. start pulsed at cycles 3 and 10 of an active run -> ignored; exactly one sequence and one done observed.
